nap_countdown: RTL and testbench
================================

# nap_countdown

Nap-timer countdown engine that consumes the time-setting pulses produced by the keypad selector. In SETTING it accumulates 5 s / 30 s / 1 min increments into a BCD display value. On `completeSetting` it counts that value down once per second and raises a latched alarm at 0:00. It sits between the keypad selector and the 7-segment/alarm drivers.

## Interface
- `TICKS_PER_SEC`, default 1000: clock cycles per counted second; legal range is 2 or more.
- `clock` input, 1 bit: single system clock; everything is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `one_sec` input, 4 bits: seconds-ones increment, BCD. Nonzero for one cycle per key press.
- `ten_sec` input, 4 bits: seconds-tens increment, BCD. Nonzero for one cycle per key press.
- `one_min` input, 4 bits: minutes increment, BCD. Nonzero for one cycle per key press.
- `completeSetting` input, 1 bit: one-cycle start/acknowledge pulse.
- `stop` input, 1 bit: level abort; cancels a run or clears an alarm.
- `disp_sec1` output, 4 bits: seconds ones, BCD, range 0–9.
- `disp_sec10` output, 4 bits: seconds tens, BCD, range 0–5.
- `disp_min` output, 4 bits: minutes, BCD, range 0–9.
- `running` output, 1 bit: high while in RUN.
- `alarm` output, 1 bit: high while in ALARM.

## Operation
- States are SETTING, RUN and ALARM. Reset enters SETTING with display 0:00, `running`=0 and `alarm`=0.
- SETTING, accumulate:
  - Each cycle, add `one_sec` + 10·`ten_sec` + 60·`one_min` seconds to the held total.
  - Express the result as minutes:tens:ones BCD.
  - Saturate at 9:59 (599 s). Any sum above 599 loads 9:59.
  - Input digits above 9 are treated as 0.
- SETTING, start:
  - `completeSetting`=1 with a nonzero total goes to RUN and clears the prescaler.
  - Increment inputs in that same cycle are ignored.
  - `completeSetting` with a 0:00 total is ignored and the block stays in SETTING.
- SETTING, `stop`: clears the total to 0:00.
- RUN:
  - The prescaler counts 0..`TICKS_PER_SEC`-1. At the terminal count the display decrements by 1 s with BCD borrow: sec1 9→…→0, then sec10 decrements and sec1 reloads 9; sec10 0 borrows from min and reloads 5.
  - Increment inputs are ignored. `completeSetting` is ignored.
  - `stop` goes to SETTING with display 0:00; it takes priority over a tick in the same cycle.
- RUN→ALARM: the tick that decrements 0:01→0:00 also enters ALARM on the same edge.
- ALARM:
  - The display holds 0:00 and `alarm` stays high.
  - `stop` goes to SETTING at 0:00.
  - `completeSetting` behaves as described in Configuration.
  - `stop` wins when both are asserted.
- Reset mid-run or mid-alarm returns to the reset state on the next edge. No partial state is kept.

## Timing
- All outputs are registered; each output changes on the edge after the input that causes it.
- Accumulation latency: an increment sampled on edge N appears on the display after edge N.
- Start latency: `completeSetting` sampled on edge N makes `running` go to 1 after edge N. The first decrement occurs after edge N+`TICKS_PER_SEC`.
- Countdown period: successive decrements are exactly `TICKS_PER_SEC` cycles apart.
- Total RUN duration for a T-second setting is T·`TICKS_PER_SEC` cycles. `alarm` rises on the same edge on which `running` falls.
- `stop` latency: one edge.

## Configuration
- `NAP_SNOOZE_EN` defined: `completeSetting` in ALARM reloads 1:00, clears the prescaler and returns to RUN (snooze).
- `NAP_SNOOZE_EN` undefined: `completeSetting` in ALARM goes to SETTING with display 0:00, the same as `stop`.

## Test plan
All scenarios use `TICKS_PER_SEC`=4.
- Reset, then one `one_sec`=5 pulse, one `ten_sec`=3 pulse and one `one_min`=1 pulse → display 1:35; `running`=0.
- Set 0:05, then pulse `completeSetting` → `running`=1; the display reaches 0:04 after 4 cycles; `alarm` rises 20 cycles after the start edge with display 0:00.
- Pulse `one_min`=1 ten times, then one `one_sec`=5 pulse → display saturates at 9:59. Then pulse `completeSetting` → the first tick shows 9:58; borrow checks at 9:00→8:59 and 1:00→0:59.
- `completeSetting` at 0:00 → stays in SETTING, `running`=0. `stop` during RUN at 0:42 → next cycle 0:00, `running`=0, no alarm.
- In ALARM, pulse `completeSetting` → with the macro: 1:00 and `running`=1, then `alarm` again after 240 cycles. Without the macro: SETTING at 0:00 with `alarm`=0.
- Assert `reset` mid-RUN at 0:17 → next edge gives display 0:00, `running`=0, `alarm`=0, and increments are accepted again.

Source files
------------

// File: rtl/nap_countdown.sv
// Nap-timer countdown: accumulates BCD time increments, counts down once per second, latches an alarm at 0:00.
// Optional feature: define NAP_SNOOZE_EN so completeSetting in ALARM reloads 1:00 and resumes RUN.
module nap_countdown #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] one_sec,
  input  logic [3:0] ten_sec,
  input  logic [3:0] one_min,
  input  logic       completeSetting,
  input  logic       stop,
  output logic [3:0] disp_sec1,
  output logic [3:0] disp_sec10,
  output logic [3:0] disp_min,
  output logic       running,
  output logic       alarm
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [10:0]   MAX_SEC   = 11'd599;

  typedef enum logic [1:0] {
    ST_SETTING = 2'd0,
    ST_RUN     = 2'd1,
    ST_ALARM   = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [3:0]    sec1_r, sec10_r, min_r;
  logic [3:0]    sec1_s, sec10_s, min_s;
  logic [PW-1:0] presc_r, presc_s;
  logic          running_r, alarm_r;
  logic [10:0]   sum_s, sat_s;
  logic          nonzero_s, last_s;

  function automatic logic [3:0] digit_clean(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  function automatic logic [10:0] to_seconds(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
    return (11'(m) * 11'd60) + (11'(t) * 11'd10) + 11'(o);
  endfunction

  // Returns {minutes, seconds-tens, seconds-ones}; argument is at most 599.
  function automatic logic [11:0] from_seconds(input logic [10:0] s);
    logic [10:0] rem;
    rem = s % 11'd60;
    return {4'(s / 11'd60), 4'(rem / 11'd10), 4'(rem % 11'd10)};
  endfunction

  assign sum_s     = to_seconds(min_r, sec10_r, sec1_r)
                   + to_seconds(digit_clean(one_min), digit_clean(ten_sec), digit_clean(one_sec));
  assign sat_s     = (sum_s > MAX_SEC) ? MAX_SEC : sum_s;
  assign nonzero_s = |{min_r, sec10_r, sec1_r};
  assign last_s    = (min_r == 4'd0) && (sec10_r == 4'd0) && (sec1_r == 4'd1);

  // Next-state, next-display and prescaler logic.
  always_comb begin
    state_s = state_r;
    sec1_s  = sec1_r;
    sec10_s = sec10_r;
    min_s   = min_r;
    presc_s = presc_r;
    case (state_r)
      ST_SETTING: begin
        if (stop) begin
          {min_s, sec10_s, sec1_s} = 12'd0;
        end else if (completeSetting && nonzero_s) begin
          state_s = ST_RUN;
          presc_s = '0;
        end else begin
          {min_s, sec10_s, sec1_s} = from_seconds(sat_s);
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_s = ST_SETTING;
          presc_s = '0;
          {min_s, sec10_s, sec1_s} = 12'd0;
        end else if (presc_r == PRESC_MAX) begin
          presc_s = '0;
          if (last_s) begin
            state_s = ST_ALARM;
          end else begin
            state_s = ST_RUN;
          end
          // BCD borrow chain: ones, then tens (reload 5), then minutes.
          if (sec1_r != 4'd0) begin
            sec1_s = sec1_r - 4'd1;
          end else if (sec10_r != 4'd0) begin
            sec1_s  = 4'd9;
            sec10_s = sec10_r - 4'd1;
          end else begin
            sec1_s  = 4'd9;
            sec10_s = 4'd5;
            min_s   = min_r - 4'd1;
          end
        end else begin
          presc_s = presc_r + PW'(1);
        end
      end
      ST_ALARM: begin
        if (stop) begin
          state_s = ST_SETTING;
          {min_s, sec10_s, sec1_s} = 12'd0;
        end else if (completeSetting) begin
`ifdef NAP_SNOOZE_EN
          state_s = ST_RUN;
          presc_s = '0;
          {min_s, sec10_s, sec1_s} = {4'd1, 4'd0, 4'd0};
`else
          state_s = ST_SETTING;
          {min_s, sec10_s, sec1_s} = 12'd0;
`endif
        end else begin
          state_s = ST_ALARM;
        end
      end
      default: begin
        state_s = ST_SETTING;
        presc_s = '0;
        {min_s, sec10_s, sec1_s} = 12'd0;
      end
    endcase
  end

  // State, display, prescaler and status flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_SETTING;
      sec1_r    <= 4'd0;
      sec10_r   <= 4'd0;
      min_r     <= 4'd0;
      presc_r   <= '0;
      running_r <= 1'b0;
      alarm_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      sec1_r    <= sec1_s;
      sec10_r   <= sec10_s;
      min_r     <= min_s;
      presc_r   <= presc_s;
      running_r <= (state_s == ST_RUN);
      alarm_r   <= (state_s == ST_ALARM);
    end
  end

  assign disp_sec1  = sec1_r;
  assign disp_sec10 = sec10_r;
  assign disp_min   = min_r;
  assign running    = running_r;
  assign alarm      = alarm_r;

endmodule

// File: tb/tb_nap_countdown.sv
// Self-checking bench for nap_countdown: directed test-plan scenarios plus randomized stimulus,
// all compared every cycle against a seconds-based behavioural model.
module tb_nap_countdown;

  localparam int T = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] one_sec, ten_sec, one_min;
  logic       completeSetting, stop;
  logic [3:0] disp_sec1, disp_sec10, disp_min;
  logic       running, alarm;

  int n_checks = 0;
  int n_fail   = 0;

  // model: 0 = setting, 1 = counting, 2 = alarm; time kept as plain seconds
  int m_mode  = 0;
  int m_total = 0;
  int m_ticks = 0;

  nap_countdown #(.TICKS_PER_SEC(T)) dut (
    .clock(clock), .reset(reset),
    .one_sec(one_sec), .ten_sec(ten_sec), .one_min(one_min),
    .completeSetting(completeSetting), .stop(stop),
    .disp_sec1(disp_sec1), .disp_sec10(disp_sec10), .disp_min(disp_min),
    .running(running), .alarm(alarm)
  );

  always #5 clock = ~clock;

  function automatic int dval(input logic [3:0] d);
    return (d > 4'd9) ? 0 : int'(d);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_mode = 0; m_total = 0; m_ticks = 0;
    end else if (m_mode == 0) begin
      if (stop) m_total = 0;
      else if (completeSetting && m_total != 0) begin
        m_mode = 1; m_ticks = 0;
      end else begin
        m_total += dval(one_sec) + 10 * dval(ten_sec) + 60 * dval(one_min);
        if (m_total > 599) m_total = 599;
      end
    end else if (m_mode == 1) begin
      if (stop) begin
        m_mode = 0; m_total = 0;
      end else begin
        m_ticks++;
        if (m_ticks == T) begin
          m_ticks = 0;
          m_total--;
          if (m_total == 0) m_mode = 2;
        end
      end
    end else begin
      if (stop) begin
        m_mode = 0; m_total = 0;
      end else if (completeSetting) begin
`ifdef NAP_SNOOZE_EN
        m_mode = 1; m_total = 60; m_ticks = 0;
`else
        m_mode = 0; m_total = 0;
`endif
      end
    end
  endtask

  task automatic compare_all();
    chk("disp_min",   32'(disp_min),   32'(m_total / 60));
    chk("disp_sec10", 32'(disp_sec10), 32'((m_total % 60) / 10));
    chk("disp_sec1",  32'(disp_sec1),  32'(m_total % 10));
    chk("running",    32'(running),    32'(m_mode == 1));
    chk("alarm",      32'(alarm),      32'(m_mode == 2));
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
    compare_all();
  endtask

  task automatic pulse(input logic [3:0] s1, input logic [3:0] s10, input logic [3:0] mn, input logic cs);
    one_sec = s1; ten_sec = s10; one_min = mn; completeSetting = cs;
    step();
    one_sec = 4'd0; ten_sec = 4'd0; one_min = 4'd0; completeSetting = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic lit(input string name, input int mn, input int s10, input int s1, input logic run, input logic alm);
    chk({name, ".min"}, 32'(disp_min),   32'(mn));
    chk({name, ".s10"}, 32'(disp_sec10), 32'(s10));
    chk({name, ".s1"},  32'(disp_sec1),  32'(s1));
    chk({name, ".run"}, 32'(running),    32'(run));
    chk({name, ".alm"}, 32'(alarm),      32'(alm));
  endtask

  initial begin
    reset = 1'b1; stop = 1'b0; completeSetting = 1'b0;
    one_sec = 4'd0; ten_sec = 4'd0; one_min = 4'd0;
    step(); step();
    lit("reset", 0, 0, 0, 1'b0, 1'b0);
    reset = 1'b0;

    pulse(4'd5, 4'd0, 4'd0, 1'b0);
    pulse(4'd0, 4'd3, 4'd0, 1'b0);
    pulse(4'd0, 4'd0, 4'd1, 1'b0);
    lit("accum_1_35", 1, 3, 5, 1'b0, 1'b0);

    do_stop();
    pulse(4'd5, 4'd0, 4'd0, 1'b0);
    pulse(4'd0, 4'd0, 4'd0, 1'b1);
    lit("start_0_05", 0, 0, 5, 1'b1, 1'b0);
    repeat (4) step();
    lit("first_tick", 0, 0, 4, 1'b1, 1'b0);
    repeat (15) step();
    lit("pre_alarm", 0, 0, 1, 1'b1, 1'b0);
    step();
    lit("alarm_edge", 0, 0, 0, 1'b0, 1'b1);
    repeat (3) step();
    lit("alarm_hold", 0, 0, 0, 1'b0, 1'b1);

    pulse(4'd0, 4'd0, 4'd0, 1'b1);
`ifdef NAP_SNOOZE_EN
    lit("snooze", 1, 0, 0, 1'b1, 1'b0);
    repeat (239) step();
    lit("snooze_pre", 0, 0, 1, 1'b1, 1'b0);
    step();
    lit("snooze_alarm", 0, 0, 0, 1'b0, 1'b1);
    do_stop();
`else
    lit("alarm_ack", 0, 0, 0, 1'b0, 1'b0);
`endif
    lit("cleared", 0, 0, 0, 1'b0, 1'b0);

    repeat (10) pulse(4'd0, 4'd0, 4'd1, 1'b0);
    pulse(4'd5, 4'd0, 4'd0, 1'b0);
    lit("saturate", 9, 5, 9, 1'b0, 1'b0);
    pulse(4'd7, 4'd0, 4'd0, 1'b1);
    lit("start_9_59", 9, 5, 9, 1'b1, 1'b0);
    repeat (4) step();
    lit("tick_9_58", 9, 5, 8, 1'b1, 1'b0);
    repeat (58 * T) step();
    lit("at_9_00", 9, 0, 0, 1'b1, 1'b0);
    repeat (T) step();
    lit("borrow_8_59", 8, 5, 9, 1'b1, 1'b0);
    repeat (479 * T) step();
    lit("at_1_00", 1, 0, 0, 1'b1, 1'b0);
    repeat (T) step();
    lit("borrow_0_59", 0, 5, 9, 1'b1, 1'b0);
    do_stop();

    pulse(4'd0, 4'd0, 4'd0, 1'b1);
    lit("cs_at_zero", 0, 0, 0, 1'b0, 1'b0);

    pulse(4'd5, 4'd4, 4'd0, 1'b0);
    pulse(4'd0, 4'd0, 4'd0, 1'b1);
    repeat (3 * T) step();
    lit("at_0_42", 0, 4, 2, 1'b1, 1'b0);
    do_stop();
    lit("stop_run", 0, 0, 0, 1'b0, 1'b0);

    pulse(4'd0, 4'd2, 4'd0, 1'b0);
    pulse(4'd0, 4'd0, 4'd0, 1'b1);
    repeat (3 * T) step();
    lit("at_0_17", 0, 1, 7, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    lit("reset_run", 0, 0, 0, 1'b0, 1'b0);
    pulse(4'd3, 4'd0, 4'd0, 1'b0);
    lit("post_reset", 0, 0, 3, 1'b0, 1'b0);

    pulse(4'd12, 4'd10, 4'd15, 1'b0);
    lit("bad_digits", 0, 0, 3, 1'b0, 1'b0);

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 6000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      reset = (r < 2);
      stop = (r >= 2 && r < 6);
      completeSetting = ($urandom_range(0, 24) == 0);
      one_sec = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      ten_sec = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      one_min = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      if (m_mode == 0 && m_total == 0 && completeSetting) begin
        one_sec = 4'd0; ten_sec = 4'd0; one_min = 4'd0;
      end
      if (m_mode == 0 && m_total > 20 && !completeSetting && $urandom_range(0, 1) == 0) begin
        stop = 1'b1;
      end
      step();
    end
    reset = 1'b0; stop = 1'b0; completeSetting = 1'b0;
    one_sec = 4'd0; ten_sec = 4'd0; one_min = 4'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
